// File: rtl/sha3_pkg.sv
// Shared SHA-3 constants for the pad loader and sponge core.
// Rate, padding bytes and loader FSM state encodings.
package sha3_pkg;

  localparam int         RATE_BYTES_256 = 136;
  localparam logic [7:0] DS_SHA3        = 8'h06;
  localparam logic [7:0] PAD_END        = 8'h80;

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;

endpackage

// File: rtl/sha3_pad_byte.sv
// Combinational byte insert plus SHA-3 domain padding.
// Reports spill when the last data byte exactly fills the block.
module sha3_pad_byte
  import sha3_pkg::*;
#(
  parameter int         RATE_BYTES = RATE_BYTES_256,
  parameter logic [7:0] DS_BYTE    = DS_SHA3,
  localparam int        CW         = $clog2(RATE_BYTES + 1),
  localparam int        W          = 8 * RATE_BYTES
) (
  input  logic [CW-1:0] cnt,
  input  logic          last,
  input  logic          empty,
  input  logic [7:0]    data,
  input  logic [W-1:0]  buffer,
  output logic [W-1:0]  block,
  output logic          spill
);

  logic          wr;
  logic          pad;
  logic [CW-1:0] p;

  assign wr    = !(last && empty);
  assign p     = wr ? cnt + CW'(1) : cnt;
  assign spill = last && (p == CW'(RATE_BYTES));
  assign pad   = last && !spill;

  // Write the byte at cnt, then OR in the pad bytes.
  always_comb begin
    block = buffer;
    for (int i = 0; i < RATE_BYTES; i++) begin
      if (wr && cnt == CW'(i))
        block[8*i +: 8] = data;
      if (pad && p == CW'(i))
        block[8*i +: 8] = block[8*i +: 8] | DS_BYTE;
    end
    if (pad)
      block[W-8 +: 8] = block[W-8 +: 8] | PAD_END;
  end

endmodule

// File: rtl/sha3_pad_loader.sv
// Byte-stream to rate-block packer with SHA-3 padding.
// FILL collects bytes; EMIT holds a block until the absorber takes it.
module sha3_pad_loader
  import sha3_pkg::*;
#(
  parameter int         RATE_BYTES = RATE_BYTES_256,
  parameter logic [7:0] DS_BYTE    = DS_SHA3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [7:0]              in_data,
  input  logic                    in_last,
  input  logic                    in_empty,
  output logic                    in_ready,
  output logic                    blk_valid,
  output logic [8*RATE_BYTES-1:0] blk_data,
  output logic                    blk_last,
  input  logic                    blk_ready,
  output logic                    busy
);

  localparam int CW = $clog2(RATE_BYTES + 1);
  localparam int W  = 8 * RATE_BYTES;

  localparam logic [W-1:0] PAD_ONLY =
    {PAD_END, {(W-16){1'b0}}, DS_BYTE};

  logic [0:0]    state_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  buf_q;
  logic          pend_q;
  logic          last_q;
  logic          busy_q;

  logic [W-1:0]  padded;
  logic          spill;
  logic          full;

  assign full = cnt_q == CW'(RATE_BYTES - 1);

  sha3_pad_byte #(
    .RATE_BYTES (RATE_BYTES),
    .DS_BYTE    (DS_BYTE)
  ) u_pad (
    .cnt    (cnt_q),
    .last   (in_last),
    .empty  (in_empty),
    .data   (in_data),
    .buffer (buf_q),
    .block  (padded),
    .spill  (spill)
  );

  // Fill/emit sequencing; a spilled last byte queues a pad-only block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      buf_q   <= '0;
      pend_q  <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        FILL: begin
          if (in_valid) begin
            buf_q  <= padded;
            busy_q <= 1'b1;
            if (in_last) begin
              state_q <= EMIT;
              cnt_q   <= '0;
              last_q  <= !spill;
              pend_q  <= spill;
            end else if (full) begin
              state_q <= EMIT;
              cnt_q   <= '0;
              last_q  <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        EMIT: begin
          if (blk_ready) begin
            if (pend_q) begin
              buf_q  <= PAD_ONLY;
              last_q <= 1'b1;
              pend_q <= 1'b0;
            end else begin
              buf_q   <= '0;
              cnt_q   <= '0;
              state_q <= FILL;
              last_q  <= 1'b0;
              if (last_q)
                busy_q <= 1'b0;
            end
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign in_ready  = state_q == FILL;
  assign blk_valid = state_q == EMIT;
  assign blk_data  = buf_q;
  assign blk_last  = last_q;
  assign busy      = busy_q;

endmodule
